// File: rtl/ui_uart_tx_arb.sv
// Round-robin arbiter and transmit sequencer: NUM_REQ byte producers share one
// UART TX line, each granted byte sent as an 8N1 / 8N2 frame on a 16x baud enable.
module ui_uart_tx_arb #(
   parameter int  NUM_REQ   = 4,
   parameter int  DATA_WID  = 8,
   parameter int  STOP_BITS = 1,
   localparam int ID_WID    = $clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        baud_x16_en,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_WID-1:0] req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        txd,
   output logic                        tx_busy,
   output logic [ID_WID-1:0]           grant_id
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t              state, state_d;
   logic [3:0]          os_cnt, os_cnt_d;
   logic [2:0]          bit_cnt, bit_cnt_d;
   logic [DATA_WID-1:0] shift, shift_d;
   logic [ID_WID-1:0]   last, last_d, gid_d;
   logic                txd_d, busy_d;
   logic [ID_WID-1:0]   pick;
   logic                any_valid;
   logic                bit_end;
   int                  idx;

   // Scan last+1 .. last+NUM_REQ; walking backwards lets the nearest valid index win.
   always_comb begin
      pick      = '0;
      any_valid = 1'b0;
      idx       = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = int'(last) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req_valid[ID_WID'(idx)]) begin
            pick      = ID_WID'(idx);
            any_valid = 1'b1;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == S_IDLE && any_valid) req_ready[pick] = 1'b1;
   end

   assign bit_end = (state != S_IDLE) && baud_x16_en && (os_cnt == 4'd15);

   always_comb begin
      state_d   = state;
      os_cnt_d  = os_cnt;
      bit_cnt_d = bit_cnt;
      shift_d   = shift;
      last_d    = last;
      gid_d     = grant_id;
      txd_d     = txd;
      busy_d    = tx_busy;

      // Counter wraps 15 -> 0 on its own, which is exactly the bit-end reload.
      if (state == S_IDLE)  os_cnt_d = 4'd0;
      else if (baud_x16_en) os_cnt_d = os_cnt + 4'd1;

      case (state)
         S_IDLE: begin
            if (any_valid) begin
               shift_d  = req_data[DATA_WID*pick +: DATA_WID];
               gid_d    = pick;
               last_d   = pick;
               os_cnt_d = 4'd0;
               txd_d    = 1'b0;
               busy_d   = 1'b1;
               state_d  = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               txd_d     = shift[0];
               bit_cnt_d = 3'd0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = shift >> 1;
               if (bit_cnt == 3'(DATA_WID-1)) begin
                  txd_d     = 1'b1;
                  bit_cnt_d = 3'd0;
                  state_d   = S_STOP;
               end else begin
                  txd_d     = shift[1];
                  bit_cnt_d = bit_cnt + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (bit_cnt == 3'(STOP_BITS-1)) begin
                  busy_d    = 1'b0;
                  bit_cnt_d = 3'd0;
                  state_d   = S_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt + 3'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         os_cnt   <= 4'd0;
         bit_cnt  <= 3'd0;
         shift    <= '0;
         last     <= ID_WID'(NUM_REQ-1);
         grant_id <= '0;
         txd      <= 1'b1;
         tx_busy  <= 1'b0;
      end else begin
         state    <= state_d;
         os_cnt   <= os_cnt_d;
         bit_cnt  <= bit_cnt_d;
         shift    <= shift_d;
         last     <= last_d;
         grant_id <= gid_d;
         txd      <= txd_d;
         tx_busy  <= busy_d;
      end
   end

endmodule

// File: tb/tb_ui_uart_tx_arb.sv
// Bench for ui_uart_tx_arb: directed frame/arbitration steps plus random traffic
// checked by a queue-based round-robin model and a UART line decoder.
module tb_ui_uart_tx_arb;
   localparam int N = 4;

   logic           clk, rst_n, baud;
   logic [N-1:0]   req_valid, req_ready, req_valid2, req_ready2;
   logic [8*N-1:0] req_data, req_data2;
   logic           txd, tx_busy, txd2, tx_busy2;
   logic [1:0]     grant_id, grant_id2;

   ui_uart_tx_arb #(.NUM_REQ(N), .DATA_WID(8), .STOP_BITS(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .baud_x16_en(baud), .req_valid(req_valid),
      .req_data(req_data), .req_ready(req_ready), .txd(txd), .tx_busy(tx_busy),
      .grant_id(grant_id));

   ui_uart_tx_arb #(.NUM_REQ(N), .DATA_WID(8), .STOP_BITS(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .baud_x16_en(baud), .req_valid(req_valid2),
      .req_data(req_data2), .req_ready(req_ready2), .txd(txd2), .tx_busy(tx_busy2),
      .grant_id(grant_id2));

   typedef struct packed {logic [1:0] id; logic [7:0] data;} exp_t;

   int         n_assert = 0, n_fail = 0;
   int         bp = 50;          // clocks per baud_x16_en pulse
   int         rgap = 0;         // random re-present gap enable
   int         mdl_last = N-1;
   int         frames = 0;
   logic [7:0] src_q [N][$];
   exp_t       exp_q[$];
   int         mon_ids[$];
   int         gap [N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit srcs_empty();
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drain(input string tag, input int lim);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && tx_busy === 1'b0 && req_valid == '0 && srcs_empty())
             && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(n < lim), 1);
   endtask

   task automatic model_reset();
      exp_q.delete();
      mdl_last = N-1;
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      int bcnt;
      baud = 1'b0;
      bcnt = 0;
      forever begin
         @(posedge clk); #1;
         baud = (bcnt == 0);
         bcnt = (bcnt + 1 >= bp) ? 0 : bcnt + 1;
      end
   end

   // Requesters: present queued bytes, hold until accepted; model predicts each grant.
   initial begin
      logic [N-1:0] hs;
      int           pick, idx;
      exp_t         e;
      req_valid = '0;
      req_data  = '0;
      forever begin
         @(negedge clk);
         hs = req_valid & req_ready;
         if (rst_n === 1'b1 && req_ready != '0) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
               idx = (mdl_last + k) % N;
               if (pick < 0 && req_valid[idx]) pick = idx;
            end
            if (pick < 0) chk("ready_without_valid", 32'(req_ready), 0);
            else begin
               chk("rr_pick", 32'(req_ready), 32'(1) << pick);
               e.id   = 2'(pick);
               e.data = req_data[8*pick +: 8];
               exp_q.push_back(e);
               mdl_last = pick;
            end
         end
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
               void'(src_q[i].pop_front());
               req_valid[i] = 1'b0;
               gap[i] = rgap ? $urandom_range(0, 3) : 0;
            end else if (!req_valid[i]) begin
               if (gap[i] > 0) gap[i]--;
               else if (src_q[i].size() > 0) begin
                  req_valid[i]       = 1'b1;
                  req_data[8*i +: 8] = src_q[i][0];
               end
            end
         end
      end
   end

   // Line decoder: samples each bit well inside its window, tolerant of start-bit stretch.
   initial begin
      logic       prev, ok;
      logic [9:0] fb;
      int         p, t;
      exp_t       e;
      prev = 1'b1;
      fb   = '0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && prev && txd === 1'b0) begin
            p  = bp;
            ok = 1'b1;
            t  = 0;
            for (int j = 0; j < 10; j++) begin
               while (t < 16*p*j + 7*p) begin
                  @(negedge clk);
                  t++;
                  if (rst_n !== 1'b1) begin ok = 1'b0; break; end
               end
               if (!ok) break;
               fb[j] = txd;
            end
            if (ok) begin
               if (exp_q.size() == 0) chk("frame_unexpected", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("frame_start", 32'(fb[0]), 0);
                  chk("frame_stop", 32'(fb[9]), 1);
                  chk("frame_byte", 32'(fb[8:1]), 32'(e.data));
                  chk("frame_id", 32'(grant_id), 32'(e.id));
                  mon_ids.push_back(int'(grant_id));
                  frames++;
               end
            end
         end
         prev = txd;
      end
   end

   initial begin
      int         n, s, bad, lo, hi, frames0, total;
      logic [9:0] fr;
      logic       samp [0:8999];
      req_valid2 = '0;
      req_data2  = '0;
      rst_n      = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_txd", 32'(txd), 1);
      chk("rst_busy", 32'(tx_busy), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_gid", 32'(grant_id), 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // idle with slow baud enable
      bad = 0;
      repeat (2000) begin
         @(negedge clk);
         if (txd !== 1'b1 || tx_busy !== 1'b0 || req_ready !== '0) bad++;
      end
      chk("idle_quiet", 32'(bad), 0);

      // single 0xA5 from requester 2, 800-clk bits
      src_q[2].push_back(8'hA5);
      n = 0;
      while (req_ready === '0 && n < 200) begin @(negedge clk); n++; end
      chk("a5_ready", 32'(req_ready), 32'h4);
      @(negedge clk);
      chk("a5_ready_pulse", 32'(req_ready), 0);
      chk("a5_gid", 32'(grant_id), 2);
      chk("a5_busy", 32'(tx_busy), 1);
      n = 0;
      while (tx_busy === 1'b1 && n < 9000) begin samp[n] = txd; n++; @(negedge clk); end
      chk("a5_busy_fall", 32'(tx_busy), 0);
      chk("a5_idle_txd", 32'(txd), 1);
      s = n - 7200;
      chk("a5_start_len", 32'(s >= 750 && s <= 850), 1);
      fr = {1'b1, 8'hA5, 1'b0};
      if (s >= 750 && s <= 850) begin
         for (int j = 0; j < 10; j++) begin
            lo  = (j == 0) ? 0 : s + 800*(j-1);
            hi  = (j == 0) ? s : s + 800*j;
            bad = 0;
            for (int k = lo; k < hi; k++) if (samp[k] !== fr[j]) bad++;
            chk($sformatf("a5_bit%0d", j), 32'(bad), 0);
         end
      end

      // reset in the middle of a frame
      bp = 1;
      src_q[0].push_back(8'h3C);
      n = 0;
      while (req_ready === '0 && n < 200) begin @(negedge clk); n++; end
      repeat (40) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_txd", 32'(txd), 1);
      chk("midrst_busy", 32'(tx_busy), 0);
      chk("midrst_gid", 32'(grant_id), 0);
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      src_q[0].push_back(8'h20);
      src_q[1].push_back(8'h21);
      n = 0;
      while (req_ready === '0 && n < 200) begin @(negedge clk); n++; end
      chk("midrst_rr_ptr", 32'(req_ready), 32'h1);
      drain("midrst_drain", 2000);

      // all four held valid after a fresh reset: order 0,1,2,3
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mon_ids.delete();
      for (int i = 0; i < N; i++) src_q[i].push_back(8'(8'h10 + i));
      drain("all4_drain", 4000);
      chk("all4_count", 32'(mon_ids.size()), 4);
      for (int k = 0; k < 4 && k < mon_ids.size(); k++)
         chk($sformatf("all4_order%0d", k), 32'(mon_ids[k]), 32'(k));
      mon_ids.delete();
      src_q[3].push_back(8'h33);
      src_q[0].push_back(8'h30);
      drain("wrap_drain", 2000);
      chk("wrap_count", 32'(mon_ids.size()), 2);
      if (mon_ids.size() == 2) begin
         chk("wrap_first", 32'(mon_ids[0]), 0);
         chk("wrap_second", 32'(mon_ids[1]), 3);
      end

      // request 1 arrives while requester 0 is transmitting
      src_q[0].push_back(8'h5A);
      n = 0;
      while (req_ready === '0 && n < 200) begin @(negedge clk); n++; end
      repeat (30) @(negedge clk);
      src_q[1].push_back(8'h77);
      bad = 0;
      n = 0;
      while (tx_busy === 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
         if (tx_busy === 1'b1 && req_ready !== '0) bad++;
      end
      chk("pend_ready_low", 32'(bad), 0);
      chk("pend_first_idle_ready", 32'(req_ready), 32'h2);
      chk("pend_gap_high", 32'(txd), 1);
      @(negedge clk);
      chk("pend_start", 32'(txd), 0);
      chk("pend_gid", 32'(grant_id), 1);
      drain("pend_drain", 2000);

      // two stop bits, 64-clk bits: 0xFF then 0x55 back to back
      bp = 4;
      @(posedge clk); #1;
      req_data2  = {8'h00, 8'h00, 8'h55, 8'hFF};
      req_valid2 = 4'b0011;
      @(negedge clk);
      chk("s2_ready", 32'(req_ready2), 32'h1);
      @(posedge clk); #1 req_valid2 = 4'b0010;
      @(negedge clk);
      n  = 0;
      hi = 0;
      while (tx_busy2 === 1'b1 && n < 2000) begin
         if (txd2 === 1'b1) hi++;
         n++;
         @(negedge clk);
      end
      chk("s2_high_len", 32'(hi), 640);
      chk("s2_busy_len", 32'(n >= 701 && n <= 704), 1);
      chk("s2_next_ready", 32'(req_ready2), 32'h2);
      chk("s2_gap_high", 32'(txd2), 1);
      @(posedge clk); #1 req_valid2 = 4'b0000;
      @(negedge clk);
      chk("s2_next_start", 32'(txd2), 0);
      chk("s2_next_gid", 32'(grant_id2), 1);
      n = 0;
      while (tx_busy2 === 1'b1 && n < 1000) begin @(negedge clk); n++; end
      chk("s2_done", 32'(tx_busy2), 0);

      // random traffic
      bp      = 1;
      rgap    = 1;
      total   = 250;
      frames0 = frames;
      for (int k = 0; k < total; k++)
         src_q[$urandom_range(0, N-1)].push_back(8'($urandom));
      drain("rand_drain", 60000);
      chk("rand_frames", 32'(frames - frames0), 32'(total));
      chk("rand_exp_empty", 32'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
